pc_branch_ctrl: RTL

- Program-counter sequencer; the reader side of the single-bit flag/flip state.
- Consumes the registered flag and flip bits to resolve conditional branches and jumps, and advances the PC each cycle.
- Handles run start, stall and halt handshakes.
- Sits between the flag/flip register pair and instruction ROM addressing.

---
 rtl/pc_branch_pkg.sv | 25 ++
 rtl/pc_branch_ctrl_branch_cond.sv | 15 +
 rtl/pc_branch_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_branch_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Holds the sequencer state encoding, default widths and the offset
// sign-extension helper used by the PC adder.
package pc_branch_pkg;

    // Sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int PC_W_DEF  = 10;
    localparam int OFF_W_DEF = 8;

    // Sign-extend the low off_w bits of off to 32 bits.
    // off_w must be in the range 1..32.
    function automatic logic signed [31:0] sext_off(input logic [31:0] off,
                                                    input int unsigned off_w);
        logic signed [31:0] tmp;
        tmp = $signed(off << (32 - off_w));
        return tmp >>> (32 - off_w);
    endfunction

endpackage

// File: rtl/pc_branch_ctrl_branch_cond.sv
// Branch resolution: decides whether the current instruction redirects
// the PC. The flip bit inverts the sense of a conditional branch; an
// unconditional jump always redirects, independent of flag/flip.
module branch_cond (
    input  logic branch,
    input  logic jump,
    input  logic flagin,
    input  logic flipin,
    output logic take_target
);

    // Redirect on any jump, or on a branch whose flag differs from flip.
    assign take_target = jump | (branch & (flagin ^ flipin));

endmodule

// File: rtl/pc_branch_ctrl.sv
// Program-counter sequencer: steps the PC through instruction ROM,
// resolving conditional branches from the registered flag/flip bits and
// handling start, stall and halt.
// Optional feature macro: PC_BRANCH_CTRL_ICOUNT_EN adds a saturating
// 32-bit count of executed (non-stalled) RUN cycles on port icount.
module pc_branch_ctrl
    import pc_branch_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int OFF_W      = OFF_W_DEF,
    parameter int START_ADDR = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             stall,
    input  logic             flagin,
    input  logic             flipin,
    input  logic             branch,
    input  logic             jump,
    input  logic             halt,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             done
`ifdef PC_BRANCH_CTRL_ICOUNT_EN
    ,
    output logic [31:0]      icount
`endif
);

    localparam logic [PC_W-1:0] START_PC = START_ADDR[PC_W-1:0];

    state_e              state;
    logic   [PC_W-1:0]   pc_q;
    logic                take;
    logic signed [PC_W-1:0] off_ext;
    logic   [PC_W-1:0]   pc_next_run;
    logic                restart;

    branch_cond u_branch_cond (
        .branch      (branch),
        .jump        (jump),
        .flagin      (flagin),
        .flipin      (flipin),
        .take_target (take)
    );

    // Offset sign-extended to PC width; sums wrap modulo 2^PC_W.
    always_comb begin
        off_ext     = PC_W'(sext_off(32'(offset), OFF_W));
        pc_next_run = take ? (pc_q + off_ext) : (pc_q + 1'b1);
        restart     = start && ((state == IDLE) || (state == HALTED));
    end

    // FSM and PC register; stall freezes everything while in RUN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            pc_q  <= START_PC;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc_q  <= START_PC;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            state <= HALTED;
                        end else begin
                            pc_q <= pc_next_run;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pc   = pc_q;
    assign busy = (state == RUN);
    assign done = (state == HALTED);

`ifdef PC_BRANCH_CTRL_ICOUNT_EN
    logic [31:0] icount_q;

    // Count executed RUN cycles (halt cycle included); saturates, held in HALTED.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            icount_q <= '0;
        end else if (restart) begin
            icount_q <= '0;
        end else if ((state == RUN) && !stall && (icount_q != 32'hFFFF_FFFF)) begin
            icount_q <= icount_q + 32'd1;
        end
    end

    assign icount = icount_q;
`else
    logic unused_restart;
    assign unused_restart = restart;
`endif

endmodule
